// File: rtl/pipe_stage_buf.sv
// Elastic E->M stage register: valid/ready handshake, optional 2-entry skid,
// flush that keeps the PC field, and a saturating back-pressure counter.
module pipe_stage_buf #(
  parameter int DATA_W   = 32,
  parameter int NFIELD   = 5,
  parameter int PC_FIELD = 1,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NFIELD*DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NFIELD*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         stall_cnt
);

  // state | meaning
  // EMPTY | nothing held
  // ONE   | head entry valid
  // TWO   | head and skid entries valid (SKID=1 only)
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam int W = NFIELD * DATA_W;

  logic [1:0]   state, state_nx;
  logic [W-1:0] head, head_nx;
  logic [W-1:0] skid, skid_nx;
  logic         rdy_q;
  logic         accept, emit;

  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    head_nx  = head;
    skid_nx  = skid;
    if (flush) begin
      // Bubble keeps the PC so recovery logic can still see where it was.
      state_nx = EMPTY;
      head_nx  = '0;
      head_nx[PC_FIELD*DATA_W +: DATA_W] = head[PC_FIELD*DATA_W +: DATA_W];
      skid_nx  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nx = ONE;
            head_nx  = in_data;
          end
        end
        ONE: begin
          if (emit && accept) begin
            head_nx = in_data;
          end else if (emit) begin
            state_nx = EMPTY;
          end else if (accept) begin
            state_nx = TWO;
            skid_nx  = in_data;
          end
        end
        TWO: begin
          if (emit) begin
            state_nx = ONE;
            head_nx  = skid;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      rdy_q     <= 1'b1;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      head  <= head_nx;
      skid  <= skid_nx;
      rdy_q <= (state_nx != TWO);
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed table, hand sequences and a queue-based
// random reference for both the skid (SKID=1) and single-entry (SKID=0) builds.
module tb_pipe_stage_buf;

  localparam int DATA_W   = 32;
  localparam int NFIELD   = 5;
  localparam int PC_FIELD = 1;
  localparam int CNT_W    = 4;
  localparam int W        = NFIELD * DATA_W;

  logic             clk;
  logic             rst       [2];
  logic             in_valid  [2];
  logic             in_ready  [2];
  logic [W-1:0]     in_data   [2];
  logic             flush     [2];
  logic             out_valid [2];
  logic             out_ready [2];
  logic [W-1:0]     out_data  [2];
  logic [CNT_W-1:0] stall_cnt [2];

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_buf #(.DATA_W(DATA_W), .NFIELD(NFIELD), .PC_FIELD(PC_FIELD), .SKID(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .flush(flush[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .stall_cnt(stall_cnt[0]));

  pipe_stage_buf #(.DATA_W(DATA_W), .NFIELD(NFIELD), .PC_FIELD(PC_FIELD), .SKID(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .flush(flush[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .stall_cnt(stall_cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        chk;
    logic        e_ov;
    logic        e_ir;
    logic        cd;
    logic [31:0] e_d;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [W-1:0] mk(input logic [31:0] f0);
    logic [W-1:0] v;
    v = '0;
    v[DATA_W-1:0] = f0;
    return v;
  endfunction

  function automatic logic [W-1:0] mk_pc(input logic [31:0] pc, input logic [31:0] other);
    logic [W-1:0] v;
    for (int k = 0; k < NFIELD; k++)
      v[k*DATA_W +: DATA_W] = (k == PC_FIELD) ? pc : other;
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] v;
    for (int k = 0; k < NFIELD; k++)
      v[k*DATA_W +: DATA_W] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic iv, input logic [W-1:0] din,
                       input logic fl, input logic ordy);
    rst[d]       = r;
    in_valid[d]  = iv;
    in_data[d]   = din;
    flush[d]     = fl;
    out_ready[d] = ordy;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    drive(d, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    edge_step();
    drive(d, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Reference: an ordered list of held beats with a capacity given by the build.
  task automatic random_run(input int d, input int n_cyc);
    logic [W-1:0] q[$];
    logic [3:0]   mcnt;
    logic         r, iv, fl, ordy, e_ov, e_ir;
    logic [W-1:0] din;
    do_reset(d);
    q.delete();
    mcnt = '0;
    for (int c = 0; c < n_cyc; c++) begin
      r    = ($urandom_range(0, 99) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 19) == 0);
      din  = rnd_data();
      drive(d, r, iv, din, fl, ordy);
      @(negedge clk);
      e_ov = (q.size() != 0);
      e_ir = (d == 1) ? (q.size() < 2) : (q.size() == 0 || ordy);
      chk($sformatf("rnd%0d out_valid c%0d", d, c), W'(out_valid[d]), W'(e_ov));
      chk($sformatf("rnd%0d in_ready c%0d", d, c), W'(in_ready[d]), W'(e_ir));
      chk($sformatf("rnd%0d stall_cnt c%0d", d, c), W'(stall_cnt[d]), W'(mcnt));
      if (e_ov) chk($sformatf("rnd%0d out_data c%0d", d, c), out_data[d], q[0]);
      edge_step();
      if (r) begin
        q.delete();
        mcnt = '0;
      end else begin
        if (e_ov && !ordy && mcnt != 4'hF) mcnt++;
        if (e_ov && ordy) void'(q.pop_front());
        if (fl) q.delete();
        else if (iv && e_ir) q.push_back(din);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    tbl[0]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    4'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,    4'd0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3000, 4'd0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    4'd0};
    tbl[4]  = '{1'b0, 1'b1, 32'h11,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    4'd0};
    tbl[5]  = '{1'b0, 1'b1, 32'h22,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11,   4'd0};
    tbl[6]  = '{1'b0, 1'b1, 32'h33,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11,   4'd1};
    tbl[7]  = '{1'b0, 1'b1, 32'h33,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11,   4'd2};
    tbl[8]  = '{1'b0, 1'b1, 32'h33,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11,   4'd3};
    tbl[9]  = '{1'b0, 1'b1, 32'h33,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22,   4'd3};
    tbl[10] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33,   4'd3};
    tbl[11] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    4'd3};

    #1;
    for (int i = 0; i < 12; i++) begin
      drive(1, tbl[i].rst, tbl[i].iv, mk(tbl[i].d), 1'b0, tbl[i].ordy);
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d out_valid", i), W'(out_valid[1]), W'(tbl[i].e_ov));
        chk($sformatf("tbl%0d in_ready", i), W'(in_ready[1]), W'(tbl[i].e_ir));
        chk($sformatf("tbl%0d stall_cnt", i), W'(stall_cnt[1]), W'(tbl[i].e_cnt));
        if (tbl[i].cd) chk($sformatf("tbl%0d out_data", i), out_data[1], mk(tbl[i].e_d));
      end
      edge_step();
    end

    // Eight back-to-back beats through the skid build.
    do_reset(1);
    for (int i = 0; i <= 8; i++) begin
      drive(1, 1'b0, (i < 8), mk(32'h100 + 32'(i)), 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("stream in_ready %0d", i), W'(in_ready[1]), W'(1'b1));
      if (i > 0) begin
        chk($sformatf("stream out_valid %0d", i), W'(out_valid[1]), W'(1'b1));
        chk($sformatf("stream out_data %0d", i), out_data[1], mk(32'h100 + 32'(i - 1)));
      end
      edge_step();
    end
    drive(1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("stream drained", W'(out_valid[1]), W'(1'b0));
    chk("stream stall_cnt", W'(stall_cnt[1]), W'(0));
    edge_step();

    // Flush with a concurrent input beat: PC survives, other fields clear, D is dropped.
    do_reset(1);
    drive(1, 1'b0, 1'b1, mk_pc(32'h3010, 32'hDEADBEEF), 1'b0, 1'b0);
    edge_step();
    drive(1, 1'b0, 1'b1, mk_pc(32'h44, 32'h44), 1'b1, 1'b0);
    @(negedge clk);
    chk("flush held beat", out_data[1], mk_pc(32'h3010, 32'hDEADBEEF));
    edge_step();
    drive(1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush out_valid", W'(out_valid[1]), W'(1'b0));
    chk("flush out_data", out_data[1], mk_pc(32'h3010, 32'h0));
    chk("flush in_ready", W'(in_ready[1]), W'(1'b1));
    for (int i = 0; i < 3; i++) begin
      edge_step();
      @(negedge clk);
      chk($sformatf("flush no D %0d", i), W'(out_valid[1]), W'(1'b0));
    end
    edge_step();

    // Counter saturation, and flush leaves the count alone.
    do_reset(1);
    drive(1, 1'b0, 1'b1, mk(32'h77), 1'b0, 1'b0);
    edge_step();
    drive(1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) edge_step();
    @(negedge clk);
    chk("sat stall_cnt", W'(stall_cnt[1]), W'(4'hF));
    chk("sat out_valid", W'(out_valid[1]), W'(1'b1));
    drive(1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    edge_step();
    drive(1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sat after flush", W'(stall_cnt[1]), W'(4'hF));
    edge_step();

    // Single-entry build: combinational in_ready follows out_ready.
    do_reset(0);
    drive(0, 1'b0, 1'b1, mk(32'h55), 1'b0, 1'b0);
    edge_step();
    drive(0, 1'b0, 1'b1, mk(32'h66), 1'b0, 1'b0);
    @(negedge clk);
    chk("s0 out_valid", W'(out_valid[0]), W'(1'b1));
    chk("s0 in_ready blocked", W'(in_ready[0]), W'(1'b0));
    drive(0, 1'b0, 1'b1, mk(32'h66), 1'b0, 1'b1);
    #1;
    chk("s0 in_ready open", W'(in_ready[0]), W'(1'b1));
    chk("s0 head 55", out_data[0], mk(32'h55));
    edge_step();
    drive(0, 1'b0, 1'b1, mk(32'h88), 1'b0, 1'b1);
    @(negedge clk);
    chk("s0 b2b data", out_data[0], mk(32'h66));
    chk("s0 b2b in_ready", W'(in_ready[0]), W'(1'b1));
    edge_step();
    drive(0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("s0 b2b data2", out_data[0], mk(32'h88));
    edge_step();

    random_run(1, 400);
    random_run(0, 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
